// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg -- shared definitions for the display framebuffer.
//   FB_W / FB_H   : framebuffer geometry in pixels (row-major RGB565 words)
//   FB_AW / FB_DW : BRAM address / data widths, shared with the LCD read side
//   op_e          : command opcodes accepted by fb_writer
//   state_e       : fb_writer control states
// ---------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_W  = 240;
    localparam int FB_H  = 136;
    localparam int FB_AW = 15;
    localparam int FB_DW = 16;

    typedef enum logic [1:0] {
        OP_PIXEL = 2'd0,
        OP_RECT  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_NOP   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        FILL   = 2'd2,
        FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/fb_addr_gen.sv
// ---------------------------------------------------------------------------
// fb_addr_gen -- row-major raster walker for one rectangle.
//   load_i          : capture bounds, start at (x0_i, y0_i)
//   step_i          : advance to the next pixel (x innermost)
//   x0_i..y1_i      : inclusive rectangle bounds, sampled on load_i
//   addr_o          : row_base + x for the current pixel
//   last_o          : current pixel is (x1, y1)
// ---------------------------------------------------------------------------
module fb_addr_gen import fb_pkg::*; #(
    parameter int ROW_W = FB_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [7:0]       x0_i,
    input  logic [7:0]       x1_i,
    input  logic [7:0]       y0_i,
    input  logic [7:0]       y1_i,
    output logic [FB_AW-1:0] addr_o,
    output logic             last_o
);

    localparam logic [FB_AW-1:0] ROW_STEP = FB_AW'(ROW_W);

    logic [7:0]       x_q, x_d, y_q, y_d;
    logic [7:0]       x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
    logic [FB_AW-1:0] row_base_q, row_base_d;
    logic [FB_AW-1:0] y0_w, row_base_init;

    // For a 240-wide buffer y*240 is (y<<8)-(y<<4); the intermediate may
    // exceed 15 bits but the modular result is still exact.
    assign y0_w          = {{(FB_AW-8){1'b0}}, y0_i};
    assign row_base_init = (ROW_W == 240) ? (y0_w << 8) - (y0_w << 4)
                                          : y0_w * ROW_STEP;

    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        row_base_d = row_base_q;
        if (load_i) begin
            x_d        = x0_i;
            y_d        = y0_i;
            x0_d       = x0_i;
            x1_d       = x1_i;
            y1_d       = y1_i;
            row_base_d = row_base_init;
        end else if (step_i) begin
            if (x_q == x1_q) begin
                x_d        = x0_q;
                y_d        = y_q + 8'd1;
                row_base_d = row_base_q + ROW_STEP;
            end else begin
                x_d = x_q + 8'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '0;
            y_q        <= '0;
            x0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            row_base_q <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            row_base_q <= row_base_d;
        end
    end

    assign addr_o = row_base_q + {{(FB_AW-8){1'b0}}, x_q};
    assign last_o = (x_q == x1_q) && (y_q == y1_q);

endmodule

// File: rtl/fb_writer.sv
// ---------------------------------------------------------------------------
// fb_writer -- write-side engine for the dual-port framebuffer (port A).
//   cmd_valid/cmd_ready : command handshake (cmd_ready is a register)
//   cmd_op              : 0 pixel, 1 rect fill, 2 clear, 3 no-op
//   cmd_x0..cmd_y1      : inclusive bounds; x1/y1 ignored for pixel
//   cmd_color           : RGB565 fill value
//   port_a_*            : BRAM write port, one word per clock
//   done                : pulse after the last write, or on a no-op
//   err                 : pulse when a command is rejected
// ---------------------------------------------------------------------------
module fb_writer #(
    parameter int FB_W = fb_pkg::FB_W,
    parameter int FB_H = fb_pkg::FB_H
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [7:0]               cmd_x0,
    input  logic [7:0]               cmd_x1,
    input  logic [7:0]               cmd_y0,
    input  logic [7:0]               cmd_y1,
    input  logic [15:0]              cmd_color,
    output logic [fb_pkg::FB_AW-1:0] port_a_address,
    output logic [fb_pkg::FB_DW-1:0] port_a_in,
    output logic                     port_a_we,
    output logic                     done,
    output logic                     err
);

    import fb_pkg::*;

    localparam logic [7:0] X_MAX = 8'(FB_W - 1);
    localparam logic [7:0] Y_MAX = 8'(FB_H - 1);

    state_e           state_q, state_d;
    logic             cmd_ready_q;
    logic             done_q, done_d, err_q, err_d;
    logic [FB_DW-1:0] color_q, color_d;
    logic             load, step, last, accept, in_range;
    logic [7:0]       nx0, nx1, ny0, ny1;
    op_e              op;

    assign op     = op_e'(cmd_op);
    assign accept = cmd_valid && cmd_ready_q;

    // Pixel and clear are rewritten as rectangles so one range check and
    // one address walker serve every writing command.
    always_comb begin
        nx0 = cmd_x0;
        nx1 = cmd_x1;
        ny0 = cmd_y0;
        ny1 = cmd_y1;
        unique case (op)
            OP_PIXEL: begin
                nx1 = cmd_x0;
                ny1 = cmd_y0;
            end
            OP_CLEAR: begin
                nx0 = 8'd0;
                nx1 = X_MAX;
                ny0 = 8'd0;
                ny1 = Y_MAX;
            end
            default: ;
        endcase
        in_range = (nx0 <= nx1) && (ny0 <= ny1) && (nx1 <= X_MAX) && (ny1 <= Y_MAX);
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        color_d = color_q;
        unique case (state_q)
            INIT: state_d = IDLE;
            IDLE: begin
                if (accept) begin
                    color_d = cmd_color;
                    if (op == OP_NOP) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else if (!in_range) begin
                        state_d = FINISH;
                        err_d   = 1'b1;
                    end else begin
                        state_d = FILL;
                        load    = 1'b1;
                    end
                end
            end
            FILL: begin
                if (last) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    step = 1'b1;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    // done/err are registered on entry to FINISH, so each is high for
    // exactly the single FINISH cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            color_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= (state_d == IDLE);
            done_q      <= done_d;
            err_q       <= err_d;
            color_q     <= color_d;
        end
    end

    fb_addr_gen #(.ROW_W(FB_W)) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .step_i (step),
        .x0_i   (nx0),
        .x1_i   (nx1),
        .y0_i   (ny0),
        .y1_i   (ny1),
        .addr_o (port_a_address),
        .last_o (last)
    );

    // Write enable decodes the state register directly, so an asynchronous
    // reset drops it immediately.
    assign port_a_we = (state_q == FILL);
    assign port_a_in = color_q;
    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
